// File: rtl/idct_transpose_buf_pkg.sv
//============================================================================
// Module  : idct_transpose_buf_pkg
// Brief   : Shared constants and types for the 4-point IDCT pipeline stages.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

package idct_transpose_buf_pkg;

    localparam int IDCT_DATA_W   = 25;
    localparam int IDCT_N        = 4;
    localparam int IDCT_CLIP_MIN = -32768;
    localparam int IDCT_CLIP_MAX = 32767;
    localparam int IDCT_SHIFT_1  = 7;
    localparam int IDCT_SHIFT_2  = 12;

    typedef logic [3:0] idct_ptr_t;
    typedef logic [1:0] idct_col_t;

    function automatic logic idct_is_last_col(input idct_col_t col);
        return col == idct_col_t'(IDCT_N - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/idct_transpose_buf_bank.sv
//============================================================================
// Module  : idct_tb_bank
// Brief   : One 16-entry transpose bank: row-major write port, 4-wide column read.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module idct_tb_bank
    import idct_transpose_buf_pkg::*;
#(
    parameter int DATA_W = IDCT_DATA_W
) (
    input  logic              clk,
    input  logic              we,
    input  idct_ptr_t         waddr,
    input  logic [DATA_W-1:0] wdata,
    input  idct_col_t         rcol,
    output logic [DATA_W-1:0] rdata [4]
);

    // Contents are deliberately not reset; validity is tracked by the owner.
    logic [DATA_W-1:0] r_mem [16];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Address is {row, col}, so a column read picks entries col, col+4, col+8, col+12.
    generate
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign rdata[r] = r_mem[{2'(r), rcol}];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/idct_transpose_buf.sv
//============================================================================
// Module  : idct_transpose_buf
// Brief   : Ping-pong 4x4 transpose buffer between row and column IDCT passes.
//           Define IDCT_TRANSPOSE_CLIP_EN to saturate inputs to signed 16 bits.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module idct_transpose_buf
    import idct_transpose_buf_pkg::*;
#(
    parameter int DATA_W = IDCT_DATA_W,
    parameter int N      = IDCT_N
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_d0,
    output logic signed [DATA_W-1:0] out_d1,
    output logic signed [DATA_W-1:0] out_d2,
    output logic signed [DATA_W-1:0] out_d3,
    output logic [1:0]               out_col,
    output logic                     out_last
);

    generate
        if (N != 4) begin : g_bad_n
            $error("idct_transpose_buf: only N = 4 is supported");
        end
    endgenerate

    logic                     r_wr_bank;
    logic                     r_rd_bank;
    idct_ptr_t                r_wr_ptr;
    idct_col_t                r_rd_col;
    logic [1:0]               r_full;
    logic [1:0]               w_full_nxt;
    logic                     w_wr_acc;
    logic                     w_rd_acc;
    logic signed [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0]        w_rd0 [4];
    logic [DATA_W-1:0]        w_rd1 [4];
    logic [DATA_W-1:0]        w_col [4];

    assign in_ready  = !r_full[r_wr_bank];
    assign out_valid = r_full[r_rd_bank];
    assign w_wr_acc  = in_valid && in_ready;
    assign w_rd_acc  = out_valid && out_ready;

`ifdef IDCT_TRANSPOSE_CLIP_EN
    localparam logic signed [DATA_W-1:0] c_clip_max = DATA_W'(IDCT_CLIP_MAX);
    localparam logic signed [DATA_W-1:0] c_clip_min = DATA_W'(IDCT_CLIP_MIN);

    always_comb begin
        w_wdata = in_data;
        if (in_data > c_clip_max) begin
            w_wdata = c_clip_max;
        end else if (in_data < c_clip_min) begin
            w_wdata = c_clip_min;
        end
    end
`else
    assign w_wdata = in_data;
`endif

    // A write needs !full[wr_bank] and a read needs full[rd_bank], so the two
    // updates below always target different banks and never conflict.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_acc && r_wr_ptr == 4'd15) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
        if (w_rd_acc && idct_is_last_col(r_rd_col)) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_col  <= '0;
            r_full    <= '0;
        end else begin
            r_full <= w_full_nxt;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 4'd1;
                if (r_wr_ptr == 4'd15) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end
            if (w_rd_acc) begin
                r_rd_col <= r_rd_col + 2'd1;
                if (idct_is_last_col(r_rd_col)) begin
                    r_rd_bank <= ~r_rd_bank;
                end
            end
        end
    end

    idct_tb_bank #(.DATA_W(DATA_W)) u_bank0 (
        .clk   (clk),
        .we    (w_wr_acc && !r_wr_bank),
        .waddr (r_wr_ptr),
        .wdata (w_wdata),
        .rcol  (r_rd_col),
        .rdata (w_rd0)
    );

    idct_tb_bank #(.DATA_W(DATA_W)) u_bank1 (
        .clk   (clk),
        .we    (w_wr_acc && r_wr_bank),
        .waddr (r_wr_ptr),
        .wdata (w_wdata),
        .rcol  (r_rd_col),
        .rdata (w_rd1)
    );

    generate
        for (genvar r = 0; r < 4; r++) begin : g_out
            assign w_col[r] = out_valid ? (r_rd_bank ? w_rd1[r] : w_rd0[r]) : '0;
        end
    endgenerate

    assign out_d0   = w_col[0];
    assign out_d1   = w_col[1];
    assign out_d2   = w_col[2];
    assign out_d3   = w_col[3];
    assign out_col  = out_valid ? r_rd_col : 2'd0;
    assign out_last = out_valid && idct_is_last_col(r_rd_col);

endmodule

`default_nettype wire

// File: tb/tb_idct_transpose_buf.sv
//============================================================================
// Module  : tb_idct_transpose_buf
// Brief   : Directed self-checking bench for the IDCT transpose buffer.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module tb_idct_transpose_buf;

    localparam int DATA_W = 25;

    typedef struct packed {
        logic signed [DATA_W-1:0] d0;
        logic signed [DATA_W-1:0] d1;
        logic signed [DATA_W-1:0] d2;
        logic signed [DATA_W-1:0] d3;
        logic [1:0]               col;
    } col_exp_t;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic signed [DATA_W-1:0] out_d0, out_d1, out_d2, out_d3;
    logic [1:0]               out_col;
    logic                     out_last;

    int       n_tests = 0;
    int       n_fail  = 0;
    int       acc_cnt = 0;
    bit       mon_en  = 1'b0;
    col_exp_t expq[$];

    idct_transpose_buf #(.DATA_W(DATA_W), .N(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_d0    (out_d0),
        .out_d1    (out_d1),
        .out_d2    (out_d2),
        .out_d3    (out_d3),
        .out_col   (out_col),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected columns of a block whose sample k equals s[k].
    task automatic push_arr(input int s [16]);
        col_exp_t e;
        for (int c = 0; c < 4; c++) begin
            e.d0  = DATA_W'(s[c]);
            e.d1  = DATA_W'(s[4 + c]);
            e.d2  = DATA_W'(s[8 + c]);
            e.d3  = DATA_W'(s[12 + c]);
            e.col = 2'(c);
            expq.push_back(e);
        end
    endtask

    task automatic push_block(input int base, input int step);
        int s [16];
        for (int k = 0; k < 16; k++) s[k] = base + step * k;
        push_arr(s);
    endtask

    // One clock: observe at the falling edge, then advance past the rising edge.
    task automatic tick();
        col_exp_t e;
        @(negedge clk);
        if (mon_en && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                check("unexpected column", 1, 0);
            end else begin
                e = expq.pop_front();
                check("col d0", out_d0, e.d0);
                check("col d1", out_d1, e.d1);
                check("col d2", out_d2, e.d2);
                check("col d3", out_d3, e.d3);
                check("col idx", out_col, e.col);
                check("col last", out_last, e.col == 2'd3);
            end
        end
        if (in_valid && in_ready) acc_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while (expq.size() != 0 && n < max_cyc) begin
            tick();
            n++;
        end
        check("drain remaining", expq.size(), 0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        acc_cnt  = 0;
        expq.delete();
    endtask

    initial begin
        int  s [16];
        int  fall_idx;
        bit  ir_drop;
        bit  unstable;

        // Reset state
        #2;
        check("rst in_ready", in_ready, 1);
        check("rst out_valid", out_valid, 0);
        check("rst out_d0", out_d0, 0);
        check("rst out_d3", out_d3, 0);
        check("rst out_col", out_col, 0);
        check("rst out_last", out_last, 0);
        do_reset();
        mon_en = 1'b1;

        // Single block
        out_ready = 1'b1;
        push_block(0, 1);
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(k);
            if (k == 15) check("t1 valid before 16th", out_valid, 0);
            tick();
        end
        in_valid = 1'b0;
        check("t1 valid after 16th", out_valid, 1);
        check("t1 first col d1", out_d1, 4);
        drain(20);

        // Back-to-back blocks
        do_reset();
        out_ready = 1'b1;
        push_block(100, 1);
        push_block(200, 1);
        push_block(300, 1);
        ir_drop = 1'b0;
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 16; k++) begin
                in_valid = 1'b1;
                in_data  = DATA_W'(100 * (b + 1) + k);
                if (!in_ready) ir_drop = 1'b1;
                tick();
            end
        end
        in_valid = 1'b0;
        check("t2 in_ready never low", ir_drop, 0);
        check("t2 accepts", acc_cnt, 48);
        drain(30);

        // Backpressure
        do_reset();
        out_ready = 1'b0;
        push_block(500, 1);
        push_block(516, 1);
        fall_idx = -1;
        unstable = 1'b0;
        for (int k = 0; k < 40; k++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(500 + k);
            if (!in_ready && fall_idx < 0) fall_idx = k;
            if (k >= 16 && (out_valid !== 1'b1 || out_d0 !== 25'sd500 || out_col !== 2'd0))
                unstable = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("t3 in_ready fall index", fall_idx, 32);
        check("t3 accepts", acc_cnt, 32);
        check("t3 in_ready low", in_ready, 0);
        check("t3 stable col0", unstable, 0);
        check("t3 hold d0", out_d0, 500);
        check("t3 hold d1", out_d1, 504);
        check("t3 hold d2", out_d2, 508);
        check("t3 hold d3", out_d3, 512);
        check("t3 hold col", out_col, 0);
        out_ready = 1'b1;
        drain(20);

        // Final write of bank 1 coincides with column-3 read of bank 0
        do_reset();
        out_ready = 1'b0;
        push_block(600, 1);
        push_block(700, 1);
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(600 + k);
            tick();
        end
        for (int k = 0; k < 12; k++) begin
            in_data = DATA_W'(700 + k);
            tick();
        end
        out_ready = 1'b1;
        for (int k = 12; k < 16; k++) begin
            in_data = DATA_W'(700 + k);
            if (k == 15) begin
                check("t4 pre col3", out_col, 3);
                check("t4 pre in_ready", in_ready, 1);
            end
            tick();
        end
        in_valid = 1'b0;
        check("t4 bank1 full", out_valid, 1);
        check("t4 bank0 free", in_ready, 1);
        check("t4 next col", out_col, 0);
        check("t4 next d0", out_d0, 700);
        drain(20);

        // Reset in the middle of a block
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(900 + k);
            tick();
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        check("t5 in_ready in reset", in_ready, 1);
        check("t5 out_valid in reset", out_valid, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        push_block(-1, -1);
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(-(k + 1));
            tick();
        end
        in_valid = 1'b0;
        drain(20);

        // Saturation of out-of-range samples
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) s[k] = k;
        s[0] = 40000;
        s[1] = -40000;
        s[2] = 1234;
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(s[k]);
            tick();
        end
        in_valid = 1'b0;
`ifdef IDCT_TRANSPOSE_CLIP_EN
        s[0] = 32767;
        s[1] = -32768;
`endif
        push_arr(s);
        drain(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
